// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus between the program sequencer, ROM, ALU and fetch logic
interface instr_fetch_if #(parameter int PC_W = 10);
  logic            Start;
  logic [8:0]      InstIn;
  logic            ConditionalBranch;
  logic            LutWe;
  logic [4:0]      LutAddr;
  logic [PC_W-1:0] LutData;
  logic [PC_W-1:0] InstAddr;
  logic            Type;
  logic [3:0]      RTypeOP;
  logic [2:0]      ITypeOP;
  logic [4:0]      ImmediateIn;
  logic            Running;
  logic            Done;
  logic [15:0]     CycleCount;
  modport master (output Start, InstIn, ConditionalBranch, LutWe, LutAddr, LutData,
                  input InstAddr, Type, RTypeOP, ITypeOP, ImmediateIn, Running, Done, CycleCount);
  modport slave (input Start, InstIn, ConditionalBranch, LutWe, LutAddr, LutData,
                 output InstAddr, Type, RTypeOP, ITypeOP, ImmediateIn, Running, Done, CycleCount);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencer with branch-target table, field split, run handshake and cycle counter
module instr_fetch #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [8:0]      HALT_INST  = 9'h1FF
) (
  input logic          Clk,
  input logic          ResetN,
  instr_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [PC_W-1:0] r_lut [32];
  logic [15:0]     r_cnt;
  logic            w_halt, w_is_branch, w_launch;
  logic [4:0]      w_idx;
  assign w_halt      = bus.InstIn == HALT_INST;
  assign w_is_branch = (!bus.InstIn[8] && bus.InstIn[7:4] == 4'd11) || (bus.InstIn[8] && bus.InstIn[7:5] == 3'd3);
  assign w_idx       = bus.InstIn[8] ? bus.InstIn[4:0] : {1'b0, bus.InstIn[3:0]};
  assign w_launch    = bus.Start && r_state != RUN;
  // state register
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) r_state <= IDLE;
    else r_state <= w_next;
  // next state: Start is only honoured outside RUN, halt ends the run
  always_comb begin
    w_next = (r_state == RUN) ? (w_halt ? DONE : RUN) : (bus.Start ? RUN : r_state);
  end
  // outputs: state decodes, instruction field slices and the sequential PC choice
  always_comb begin
    bus.Running     = r_state == RUN;
    bus.Done        = r_state == DONE;
    bus.Type        = bus.InstIn[8];
    bus.RTypeOP     = bus.InstIn[7:4];
    bus.ITypeOP     = bus.InstIn[7:5];
    bus.ImmediateIn = bus.InstIn[4:0];
    bus.InstAddr    = r_pc;
    bus.CycleCount  = r_cnt;
    w_pc_next       = w_halt ? r_pc : ((w_is_branch && bus.ConditionalBranch) ? r_lut[w_idx] : r_pc + 1'b1);
  end
  // PC and saturating run-cycle counter
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      r_pc  <= START_ADDR;
      r_cnt <= '0;
    end else if (w_launch) begin
      r_pc  <= START_ADDR;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_pc  <= w_pc_next;
      r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 16'd1;
    end
  // branch-target table; a same-cycle read sees the pre-write value
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) begin
      for (int i = 0; i < 32; i++) r_lut[i] <= '0;
    end else if (bus.LutWe) begin
      r_lut[bus.LutAddr] <= bus.LutData;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch stage that sits directly upstream of the ALU. It owns the PC, addresses the combinational instruction ROM, splits each 9-bit instruction into the ALU's Type/RTypeOP/ITypeOP/ImmediateIn fields, and consumes the ALU's ConditionalBranch to select the next PC through a 32-entry branch-target table. A Start/Done handshake brackets each program run, and a saturating cycle counter supports performance reporting.

## Interface
- PC_W, 10: PC and instruction-address width.
- START_ADDR, 0: PC value loaded on Start.
- HALT_INST, 9'h1FF: instruction encoding that ends a run.
- Clk  input  1  rising-edge clock.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins a run.
- InstIn  input  9  instruction word from the ROM at InstAddr, same cycle.
- ConditionalBranch  input  1  branch-taken flag from the ALU for the current instruction.
- LutWe  input  1  write enable for the branch-target table.
- LutAddr  input  5  branch-target table write index.
- LutData  input  PC_W  branch-target table write data.
- InstAddr  output  PC_W  registered PC.
- Type  output  1  InstIn[8].
- RTypeOP  output  4  InstIn[7:4].
- ITypeOP  output  3  InstIn[7:5].
- ImmediateIn  output  5  InstIn[4:0].
- Running  output  1  high while in RUN.
- Done  output  1  high in DONE.
- CycleCount  output  16  number of RUN cycles in the current or most recent run.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: on Start, load PC to START_ADDR, clear CycleCount, and go to RUN.
- RUN: each cycle, evaluate InstIn at InstAddr:
  - InstIn == HALT_INST: go to DONE. PC holds and CycleCount still increments for this cycle.
  - IsBranch = (Type==0 && RTypeOP==11) || (Type==1 && ITypeOP==3).
  - IsBranch && ConditionalBranch: next PC = Lut[Idx]. Idx = ImmediateIn when Type==1, otherwise {1'b0, InstIn[3:0]}.
  - Otherwise: PC + 1, wrapping modulo 2^PC_W. No error is raised on wrap.
  - ConditionalBranch is ignored when IsBranch is 0.
- DONE: Done stays high and PC holds. On Start, do the same as from IDLE: reload PC, clear CycleCount, go to RUN.
- Start while in RUN is ignored.
- Field outputs are pure combinational slices of InstIn and are valid in every state.
- Running and Done are combinational decodes of state (Running = RUN, Done = DONE).
- CycleCount increments by 1 per RUN cycle and saturates at 16'hFFFF.
- Branch-target table:
  - 32 x PC_W registers, written on a clock edge when LutWe is high. Writes are accepted in any state.
  - A write and a read of the same index in the same cycle return the old value; the new value is visible next cycle.
  - Reset clears all entries to 0.

## Timing
- Reset values: PC = START_ADDR (InstAddr = START_ADDR), state = IDLE, Running = 0, Done = 0, CycleCount = 0, Lut = all 0.
- Reset is asynchronous assert. Deassertion is sampled at the next Clk edge.
- Reset during RUN aborts immediately with no Done pulse.
- Start is sampled at a rising edge in IDLE or DONE. First fetch (InstAddr = START_ADDR, Running = 1) occurs in the following cycle.
- Branch decision is combinational from InstIn and ConditionalBranch within one cycle; the new PC appears on the next edge. Zero branch penalty, one instruction per cycle.
- Halt: on the edge after HALT_INST is presented, Done = 1 and Running = 0.
  - For a straight-line program of N instructions plus the halt, CycleCount = N+1.

## Test plan
- Reset/idle: assert ResetN=0 mid-RUN -> InstAddr=0, Running=0, Done=0, CycleCount=0 immediately. Start not pulsed -> PC stays 0 indefinitely.
- Straight-line run: ROM addresses 0..4 = ADD instructions, address 5 = 9'h1FF, pulse Start -> InstAddr sequence 0,1,2,3,4,5. Done rises the edge after address 5. CycleCount=6.
- Unconditional branch: Lut[3]=20, instruction at address 2 is B with imm 3, ConditionalBranch=1 -> InstAddr goes 2 -> 20.
- Conditional branch: BTRU with reg field 7, Lut[7]=40:
  - ConditionalBranch=0 -> PC+1.
  - ConditionalBranch=1 -> 40.
  - ConditionalBranch=1 on a non-branch ADD -> PC+1.
- Wrap and saturation: with PC_W=10, straight-line code at 1023 -> next InstAddr=0. Force a run longer than 65535 cycles -> CycleCount holds 16'hFFFF.
- Restart and LUT hazard:
  - Start in DONE -> PC=START_ADDR, CycleCount=0.
  - Start during RUN -> ignored.
  - LutWe to index 3 in the same cycle as a taken branch using index 3 -> old target used.
